// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write/read arbiters
package fifo_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;
  // Header beat layout: requester index at the bottom, all upper bits zero
  localparam int HDR_IDX_LSB = 0;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first request after the last winner
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last_idx,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);
  logic [IW-1:0] w_cand;
  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(i_last_idx) + k) % NREQ);
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
    o_onehot = o_any ? (NREQ'(1) << o_idx) : '0;
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin packet arbiter with header insertion in front of a FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DSIZE  = 8,
  parameter int HDR_EN = 1
) (
  input  logic                  i_wclk,
  input  logic                  i_wrst_n,
  input  logic [NREQ-1:0]       i_valid,
  input  logic [NREQ-1:0]       i_last,
  input  logic [NREQ*DSIZE-1:0] i_data,
  output logic [NREQ-1:0]       o_ack,
  output logic [NREQ-1:0]       o_gnt,
  output logic                  o_busy,
  output logic                  o_fifo_wr,
  output logic [DSIZE-1:0]      o_fifo_wdata,
  input  logic                  i_fifo_wfull
);
  localparam int IW = clog2(NREQ);
  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_last;
  logic [NREQ-1:0] w_pick_oh;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_any;
  logic            w_hdr_wr;
  logic            w_accept;
  logic [DSIZE-1:0] w_data_sel;
  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req      (i_valid),
    .i_last_idx (r_last),
    .o_onehot   (w_pick_oh),
    .o_idx      (w_pick_idx),
    .o_any      (w_pick_any)
  );
  assign w_data_sel   = i_data[int'(r_idx)*DSIZE +: DSIZE];
  assign w_hdr_wr     = (r_state == HDR) && !i_fifo_wfull;
  assign w_accept     = (r_state == DATA) && i_valid[r_idx] && !i_fifo_wfull;
  assign o_fifo_wr    = w_hdr_wr || w_accept;
  assign o_fifo_wdata = w_hdr_wr ? (DSIZE'(r_idx) << HDR_IDX_LSB) : w_accept ? w_data_sel : '0;
  assign o_ack        = w_accept ? r_gnt : '0;
  assign o_gnt        = r_gnt;
  assign o_busy       = r_state != IDLE;
  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_last  <= IW'(NREQ - 1);
    end else begin
      case (r_state)
        IDLE: if (w_pick_any) begin
          r_gnt   <= w_pick_oh;
          r_idx   <= w_pick_idx;
          r_state <= (HDR_EN != 0) ? HDR : DATA;
        end
        HDR: if (w_hdr_wr) r_state <= DATA;
        DATA: if (w_accept && i_last[r_idx]) begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_last  <= r_idx;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scenario and random checks of the write arbiter against a packet-level model
module tb_fifo_wr_arbiter;
  localparam int P_IDLE = 0, P_HDR = 1, P_DATA = 2;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] valid, last;
  logic [31:0] data;
  logic wfull;
  logic [3:0] ack0, gnt0, ack1, gnt1;
  logic busy0, busy1, wr0, wr1;
  logic [7:0] wd0, wd1;
  logic sel;
  logic [3:0] o_ack, o_gnt;
  logic o_busy, o_wr;
  logic [7:0] o_wd;
  logic [8:0] q[4][$];
  logic [7:0] wlog[$];
  int wcyc[$];
  logic [3:0] drop_mask;
  logic force_full;
  int drop_pct, full_pct;
  int m_phase, m_owner, m_last, cyc, gnt_cnt;
  int n_err = 0, n_chk = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .HDR_EN(1)) dut_hdr (
    .i_wclk(clk), .i_wrst_n(rst_n), .i_valid(valid), .i_last(last), .i_data(data),
    .o_ack(ack0), .o_gnt(gnt0), .o_busy(busy0), .o_fifo_wr(wr0), .o_fifo_wdata(wd0),
    .i_fifo_wfull(wfull));
  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .HDR_EN(0)) dut_nohdr (
    .i_wclk(clk), .i_wrst_n(rst_n), .i_valid(valid), .i_last(last), .i_data(data),
    .o_ack(ack1), .o_gnt(gnt1), .o_busy(busy1), .o_fifo_wr(wr1), .o_fifo_wdata(wd1),
    .i_fifo_wfull(wfull));

  assign o_ack  = sel ? ack1 : ack0;
  assign o_gnt  = sel ? gnt1 : gnt0;
  assign o_busy = sel ? busy1 : busy0;
  assign o_wr   = sel ? wr1 : wr0;
  assign o_wd   = sel ? wd1 : wd0;

  task automatic do_reset();
    valid = '0; last = '0; data = '0; wfull = 1'b0;
    drop_mask = '0; force_full = 1'b0; drop_pct = 0; full_pct = 0;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({o_gnt, o_busy, o_ack, o_wr, o_wd} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: gnt=%b busy=%b ack=%b wr=%b wd=%h, all required 0", o_gnt, o_busy, o_ack, o_wr, o_wd);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    m_phase = P_IDLE; m_owner = 0; m_last = 3; gnt_cnt = 0;
    for (int k = 0; k < 4; k++) q[k].delete();
    wlog.delete(); wcyc.delete();
  endtask

  task automatic cycle();
    logic [3:0] eg, ea;
    logic ew, lb;
    logic [7:0] ed;
    logic [8:0] fr;
    for (int k = 0; k < 4; k++) begin
      valid[k] = (q[k].size() > 0) && !drop_mask[k] && ($urandom_range(99) >= drop_pct);
      if (valid[k]) begin
        fr = q[k][0];
        data[k*8 +: 8] = fr[7:0];
        last[k] = fr[8];
      end else begin
        data[k*8 +: 8] = 8'($urandom);
        last[k] = 1'($urandom);
      end
    end
    wfull = force_full || ($urandom_range(99) < full_pct);
    #1;
    eg = (m_phase == P_IDLE) ? 4'b0 : 4'(1 << m_owner);
    ew = (m_phase == P_HDR) ? !wfull : (m_phase == P_DATA) ? (valid[m_owner] && !wfull) : 1'b0;
    ed = 8'h00;
    if (ew && m_phase == P_HDR) ed = 8'(m_owner);
    if (ew && m_phase == P_DATA) begin
      fr = q[m_owner][0];
      ed = fr[7:0];
    end
    ea = (ew && m_phase == P_DATA) ? eg : 4'b0;
    n_chk += 5;
    if (o_gnt !== eg) begin n_err++; $display("FAIL gnt @%0d: got %b want %b", cyc, o_gnt, eg); end
    if (o_busy !== (m_phase != P_IDLE)) begin n_err++; $display("FAIL busy @%0d: got %b want %b", cyc, o_busy, m_phase != P_IDLE); end
    if (o_wr !== ew) begin n_err++; $display("FAIL fifo_wr @%0d: got %b want %b (full=%b)", cyc, o_wr, ew, wfull); end
    if (o_wd !== ed) begin n_err++; $display("FAIL fifo_wdata @%0d: got %h want %h", cyc, o_wd, ed); end
    if (o_ack !== ea) begin n_err++; $display("FAIL ack @%0d: got %b want %b", cyc, o_ack, ea); end
    if (o_wr === 1'b1) begin wlog.push_back(o_wd); wcyc.push_back(cyc); end
    if (o_gnt !== 4'b0) gnt_cnt++;
    @(posedge clk);
    if (m_phase == P_IDLE) begin
      if (|valid) begin
        for (int j = 1; j <= 4; j++)
          if (valid[(m_last + j) % 4]) begin m_owner = (m_last + j) % 4; break; end
        m_phase = sel ? P_DATA : P_HDR;
      end
    end else if (m_phase == P_HDR) begin
      if (ew) m_phase = P_DATA;
    end else if (ew) begin
      fr = q[m_owner].pop_front();
      lb = fr[8];
      if (lb) begin m_phase = P_IDLE; m_last = m_owner; end
    end
    cyc++;
    #1;
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0 || m_phase != P_IDLE) && n < max_cyc) begin
      cycle();
      n++;
    end
    n_chk++;
    if (n >= max_cyc) begin n_err++; $display("FAIL drain_timeout: traffic still pending after %0d cycles", n); end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) cycle();
  endtask

  task automatic test_single_packet();
    logic [7:0] exp_s[4];
    exp_s = '{8'h00, 8'hA1, 8'hA2, 8'hA3};
    sel = 1'b0;
    do_reset();
    q[0].push_back({1'b0, 8'hA1}); q[0].push_back({1'b0, 8'hA2}); q[0].push_back({1'b1, 8'hA3});
    run_until_idle(20);
    n_chk += 2;
    if (gnt_cnt !== 4) begin n_err++; $display("FAIL single_gnt_cycles: got %0d want 4", gnt_cnt); end
    if (wlog.size() != 4) begin n_err++; $display("FAIL single_write_count: got %0d want 4", wlog.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (wlog[i] !== exp_s[i]) begin n_err++; $display("FAIL single_stream[%0d]: got %h want %h", i, wlog[i], exp_s[i]); end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_h[5];
    exp_h = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
    sel = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) q[k].push_back({1'b1, 8'(8'h10 * (k + 1))});
    q[0].push_back({1'b1, 8'h55});
    run_until_idle(40);
    n_chk++;
    if (wlog.size() != 10) begin n_err++; $display("FAIL rr_write_count: got %0d want 10", wlog.size()); end
    else for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (wlog[2*i] !== exp_h[i]) begin n_err++; $display("FAIL rr_header[%0d]: got %h want %h", i, wlog[2*i], exp_h[i]); end
    end
  endtask

  task automatic test_full_stall();
    int wr_before;
    logic [7:0] exp_f[5];
    exp_f = '{8'h01, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) q[1].push_back({1'(i == 3), 8'(8'hB0 + i)});
    for (int i = 0; i < 3; i++) cycle();
    wr_before = wlog.size();
    force_full = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    force_full = 1'b0;
    n_chk++;
    if (wlog.size() != wr_before) begin n_err++; $display("FAIL stall_writes: got %0d writes during full want 0", wlog.size() - wr_before); end
    run_until_idle(20);
    n_chk++;
    if (wlog.size() != 5) begin n_err++; $display("FAIL stall_write_count: got %0d want 5", wlog.size()); end
    else for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (wlog[i] !== exp_f[i]) begin n_err++; $display("FAIL stall_stream[%0d]: got %h want %h", i, wlog[i], exp_f[i]); end
    end
  endtask

  task automatic test_bubble();
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) q[2].push_back({1'(i == 3), 8'(8'hC0 + i)});
    q[1].push_back({1'b1, 8'hD0});
    drop_mask = 4'b0010;
    cycle();
    drop_mask = 4'b0000;
    cycle(); cycle();
    drop_mask = 4'b0100;
    for (int i = 0; i < 3; i++) cycle();
    n_chk++;
    if (o_gnt !== 4'b0100) begin n_err++; $display("FAIL bubble_hold: got %b want 0100", o_gnt); end
    drop_mask = 4'b0000;
    run_until_idle(20);
    n_chk++;
    if (wlog.size() != 7) begin n_err++; $display("FAIL bubble_write_count: got %0d want 7", wlog.size()); end
    else begin
      n_chk += 2;
      if (wlog[0] !== 8'h02) begin n_err++; $display("FAIL bubble_first_hdr: got %h want 02", wlog[0]); end
      if (wlog[5] !== 8'h01) begin n_err++; $display("FAIL bubble_second_hdr: got %h want 01", wlog[5]); end
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) q[1].push_back({1'(i == 3), 8'(8'hE0 + i)});
    for (int i = 0; i < 3; i++) cycle();
    do_reset();
    q[0].push_back({1'b1, 8'h77});
    q[3].push_back({1'b1, 8'h88});
    run_until_idle(20);
    n_chk++;
    if (wlog.size() != 4) begin n_err++; $display("FAIL rstmid_write_count: got %0d want 4", wlog.size()); end
    else begin
      n_chk++;
      if (wlog[0] !== 8'h00) begin n_err++; $display("FAIL rstmid_first_winner: got %h want 00", wlog[0]); end
    end
  endtask

  task automatic test_no_hdr();
    int c0;
    sel = 1'b1;
    do_reset();
    q[3].push_back({1'b0, 8'h3A}); q[3].push_back({1'b1, 8'h3B});
    c0 = cyc;
    run_until_idle(20);
    n_chk++;
    if (wlog.size() != 2) begin n_err++; $display("FAIL nohdr_write_count: got %0d want 2", wlog.size()); end
    else begin
      n_chk += 3;
      if (wlog[0] !== 8'h3A) begin n_err++; $display("FAIL nohdr_beat0: got %h want 3a", wlog[0]); end
      if (wlog[1] !== 8'h3B) begin n_err++; $display("FAIL nohdr_beat1: got %h want 3b", wlog[1]); end
      if (wcyc[0] !== c0 + 1) begin n_err++; $display("FAIL nohdr_latency: first write at cycle %0d want %0d", wcyc[0] - c0, 1); end
    end
  endtask

  task automatic test_random();
    int len;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      do_reset();
      for (int k = 0; k < 4; k++)
        for (int p = 0; p < 4; p++) begin
          len = $urandom_range(5, 1);
          for (int b = 0; b < len; b++) q[k].push_back({1'(b == len - 1), 8'($urandom)});
        end
      drop_pct = 20;
      full_pct = 25;
      run_until_idle(3000);
      drop_pct = 0;
      full_pct = 0;
    end
  endtask

  initial begin
    sel = 1'b0;
    cyc = 0;
    rst_n = 1'b1;
    valid = '0; last = '0; data = '0; wfull = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_full_stall();
    test_bubble();
    test_reset_mid();
    test_no_hdr();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
